// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential 8x8 multiplier.
// Holds the FSM state enum, the step encoding for the four nibble products,
// the per-step shift table and the fixed latency in clocks.
package mult_seq_pkg;

  localparam int unsigned NIB_W      = 4;
  localparam int unsigned PP_W       = 2 * NIB_W;
  localparam int unsigned ACC_W      = 16;
  localparam int unsigned STEP_W     = 2;
  localparam int unsigned LAT_CYCLES = 4;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  typedef logic [STEP_W-1:0] step_t;

  // Nibble pair selected at each step: {a nibble, b nibble}
  localparam step_t STEP_LL = 2'd0;  // a_lo * b_lo
  localparam step_t STEP_HL = 2'd1;  // a_hi * b_lo
  localparam step_t STEP_LH = 2'd2;  // a_lo * b_hi
  localparam step_t STEP_HH = 2'd3;  // a_hi * b_hi

  // Left shift applied to each step's partial product
  localparam int unsigned SHIFT_TBL [LAT_CYCLES] = '{0, 4, 4, 8};

  // Zero-extend a partial product to accumulator width and align it
  function automatic logic [ACC_W-1:0] shift_partial(input logic [PP_W-1:0] pp,
                                                     input step_t           step);
    return ACC_W'(pp) << SHIFT_TBL[step];
  endfunction

endpackage

// File: rtl/multiplicador_4x4.sv
// Combinational 4x4 unsigned multiplier core.
// Ports:
//   a, b : 4-bit unsigned operands
//   p    : 8-bit unsigned product
module multiplicador_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  assign p = 8'(a) * 8'(b);

endmodule

// File: rtl/multiplicador_8x8_seq.sv
// Sequential 8x8 unsigned multiplier built on one combinational 4x4 core.
// The operands are captured on an accepted start, then one nibble product is
// accumulated per clock over four clocks; p is updated with a one-cycle done.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   start : request, sampled only while idle
//   a, b  : 8-bit operands, captured on accepted start
//   p     : 16-bit registered product, held until next completion
//   busy  : high while a multiplication is in progress
//   done  : one-cycle pulse when p is updated
// Build option:
//   ZERO_BYPASS_EN : a zero operand completes at the start edge (p=0, done
//                    next cycle, busy never raised) instead of running 4 steps.
module multiplicador_8x8_seq
  import mult_seq_pkg::*;
#(
  parameter int unsigned OP_W  = 8,
  parameter int unsigned CNT_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [2*OP_W-1:0] p,
  output logic              busy,
  output logic              done
);

  // Only the 8-bit / 4-step configuration is implemented
  if (OP_W != 8 || CNT_W != STEP_W) begin : g_bad_param
    $error("multiplicador_8x8_seq: only OP_W=8, CNT_W=2 supported");
  end

  state_t             state;
  step_t              cnt;
  logic [OP_W-1:0]    a_r;
  logic [OP_W-1:0]    b_r;
  logic [ACC_W-1:0]   acc;

  logic [NIB_W-1:0]   nib_a;
  logic [NIB_W-1:0]   nib_b;
  logic [PP_W-1:0]    partial;
  logic [ACC_W-1:0]   acc_sum;

  // Nibble mux feeding the 4x4 core from the captured operands
  always_comb begin
    nib_a = a_r[3:0];
    nib_b = b_r[3:0];
    case (cnt)
      STEP_HL: nib_a = a_r[7:4];
      STEP_LH: nib_b = b_r[7:4];
      STEP_HH: begin
        nib_a = a_r[7:4];
        nib_b = b_r[7:4];
      end
      default: ;
    endcase
  end

  multiplicador_4x4 u_core (
    .a (nib_a),
    .b (nib_b),
    .p (partial)
  );

  // Running sum including this step's aligned partial; max 0xFE01, no carry out
  assign acc_sum = acc + shift_partial(partial, cnt);

  // Control FSM, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= STEP_LL;
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      p     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
`ifdef ZERO_BYPASS_EN
            if (a == '0 || b == '0) begin
              p    <= '0;
              done <= 1'b1;
            end else begin
              a_r   <= a;
              b_r   <= b;
              acc   <= '0;
              cnt   <= STEP_LL;
              busy  <= 1'b1;
              state <= CALC;
            end
`else
            a_r   <= a;
            b_r   <= b;
            acc   <= '0;
            cnt   <= STEP_LL;
            busy  <= 1'b1;
            state <= CALC;
`endif
          end
        end
        CALC: begin
          if (cnt == STEP_HH) begin
            p     <= acc_sum;
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= STEP_LL;
            state <= IDLE;
          end else begin
            acc <= acc_sum;
            cnt <= cnt + STEP_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_8x8_seq.sv
// Directed bench for multiplicador_8x8_seq: a vector table of operand pairs
// with hand-computed products, plus sequences for reset, back-to-back
// starts, start-while-busy and reset during a multiplication.
module tb_multiplicador_8x8_seq;

  localparam int unsigned LAT     = 4;
  localparam int unsigned TIMEOUT = 20;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] p;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  multiplicador_8x8_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .p     (p),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [15:0] exp_p;
    string       name;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called on the negedge just after the start edge; returns edges until done
  task automatic wait_done(output int n, output int busy_hi, output bit ok);
    n       = 0;
    busy_hi = 0;
    while (!done && n < TIMEOUT) begin
      if (busy) busy_hi++;
      @(negedge clk);
      n++;
    end
    ok = done;
  endtask

  function automatic int exp_latency(input logic [7:0] va, input logic [7:0] vb);
`ifdef ZERO_BYPASS_EN
    if (va == 8'h00 || vb == 8'h00) return 0;
`endif
    return LAT;
  endfunction

  task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                        input logic [15:0] exp_p, input string name);
    int n, busy_hi, lat;
    bit ok;
    lat = exp_latency(va, vb);
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~va; b = ~vb;  // operands must not matter after capture
    wait_done(n, busy_hi, ok);
    check({name, " done_seen"}, int'(ok), 1);
    check({name, " latency"}, n, lat);
    check({name, " busy_cycles"}, busy_hi, (lat == 0) ? 0 : LAT);
    check({name, " p"}, int'(p), int'(exp_p));
    check({name, " busy_at_done"}, int'(busy), 0);
    @(negedge clk);
    check({name, " done_pulse"}, int'(done), 0);
  endtask

  vec_t vecs [10];

  initial begin
    int n, busy_hi;
    bit ok;

    vecs[0] = '{8'h12, 8'h34, 16'h03A8, "v12x34"};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, "vFFxFF"};
    vecs[2] = '{8'h00, 8'hAB, 16'h0000, "v00xAB"};
    vecs[3] = '{8'hAB, 8'h00, 16'h0000, "vABx00"};
    vecs[4] = '{8'h01, 8'h01, 16'h0001, "v01x01"};
    vecs[5] = '{8'h10, 8'h10, 16'h0100, "v10x10"};
    vecs[6] = '{8'h0F, 8'h0F, 16'h00E1, "v0Fx0F"};
    vecs[7] = '{8'h80, 8'h02, 16'h0100, "v80x02"};
    vecs[8] = '{8'h7F, 8'h81, 16'h3FFF, "v7Fx81"};
    vecs[9] = '{8'hC3, 8'h3C, 16'h2DB4, "vC3x3C"};

    // Reset held with start asserted: no capture, all outputs low
    rst_n = 1'b0; start = 1'b1; a = 8'h12; b = 8'h34;
    repeat (2) @(negedge clk);
    check("rst p", int'(p), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst busy", int'(busy), 0);
    check("post_rst done", int'(done), 0);

    foreach (vecs[i]) run_op(vecs[i].va, vecs[i].vb, vecs[i].exp_p, vecs[i].name);

    // Back-to-back: second start accepted in the done cycle
    @(negedge clk);
    a = 8'hA5; b = 8'h5A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, busy_hi, ok);
    check("b2b first latency", n, LAT);
    check("b2b first p", int'(p), 16'h3A02);
    a = 8'h0F; b = 8'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b second accepted busy", int'(busy), 1);
    check("b2b done low after accept", int'(done), 0);
    wait_done(n, busy_hi, ok);
    check("b2b second latency", n, LAT);
    check("b2b second p", int'(p), 16'h00F0);
    @(negedge clk);
    check("b2b done_pulse", int'(done), 0);

    // Start while busy is ignored
    @(negedge clk);
    a = 8'h03; b = 8'h05; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    repeat (2) begin @(negedge clk); n++; end
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    n++;
    start = 1'b0;
    while (!done && n < TIMEOUT) begin @(negedge clk); n++; end
    check("busyprot latency", n, LAT);
    check("busyprot p", int'(p), 16'h000F);
    busy_hi = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) busy_hi++;
    end
    check("busyprot extra_done", busy_hi, 0);
    check("busyprot p_hold", int'(p), 16'h000F);

    // Reset during calculation aborts: no done, p cleared
    @(negedge clk);
    a = 8'h80; b = 8'h80; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst p", int'(p), 0);
    check("midrst busy", int'(busy), 0);
    busy_hi = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) busy_hi++;
    end
    check("midrst no_activity", busy_hi, 0);
    run_op(8'h02, 8'h03, 16'h0006, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
